// File: rtl/gray_hb_wdt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gray_hb_wdt
// Description : Gray-code heartbeat monitor with watchdog. Tracks a W-bit
//               heartbeat that must walk the reflected Gray sequence
//               g(i) = i ^ (i >> 1). It flags illegal code transitions and
//               watchdog expiry, and reports health after GOOD_CYCLES
//               consecutive complete sequences.
//               Optional feature macro: GRAY_HB_WDT_ERRCNT_EN adds the
//               saturating 8-bit err_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_hb_wdt #(
    parameter int W           = 3,
    parameter int TIMEOUT     = 6100,
    parameter int CNT_W       = 24,
    parameter int GOOD_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] hb,
    output logic         health,
    output logic         seq_err,
    output logic         timeout,
    output logic         cycle_done
`ifdef GRAY_HB_WDT_ERRCNT_EN
    ,
    output logic [7:0]   err_count
`endif
);

    localparam logic [W-1:0]     c_IDX_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       c_GOOD     = 4'(GOOD_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_idx;
    logic [3:0]       r_gcnt;
    logic [CNT_W-1:0] r_cnt;

    logic [W-1:0]     w_idx_next;
    logic             w_hold;
    logic             w_adv;
    logic             w_done;
    logic             w_err;
    logic             w_expire;
    logic [3:0]       w_gcnt_inc;

    function automatic logic [W-1:0] gray(input logic [W-1:0] i);
        return i ^ (i >> 1);
    endfunction

    assign w_idx_next = r_idx + W'(1);
    assign w_hold     = (hb == gray(r_idx));
    assign w_adv      = (hb == gray(w_idx_next));
    // Wrap from the last index back to code 0 completes one sequence
    assign w_done     = (r_state == S_TRACK) && w_adv && (r_idx == c_IDX_MAX);
    assign w_err      = (r_state == S_TRACK) && !w_hold && !w_adv;
    // A completion landing on the expiry cycle wins over the timeout
    assign w_expire   = (r_cnt == c_CNT_LAST) && !w_done;
    assign w_gcnt_inc = (r_gcnt >= c_GOOD) ? c_GOOD : (r_gcnt + 4'd1);

    // Sequence tracker, watchdog counter and registered status/pulse outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_gcnt     <= '0;
            r_cnt      <= '0;
            health     <= 1'b0;
            seq_err    <= 1'b0;
            timeout    <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            seq_err    <= w_err;
            timeout    <= w_expire;
            cycle_done <= w_done;

            if (w_done || w_err || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_err || w_expire) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
                r_gcnt  <= '0;
                health  <= 1'b0;
            end else if (r_state == S_IDLE) begin
                if (hb == '0) begin
                    r_state <= S_TRACK;
                    r_idx   <= '0;
                end
            end else if (w_adv) begin
                r_idx <= w_idx_next;
                if (w_done) begin
                    r_gcnt <= w_gcnt_inc;
                    health <= (w_gcnt_inc == c_GOOD);
                end
            end
        end
    end

`ifdef GRAY_HB_WDT_ERRCNT_EN
    // Saturating count of cycles that raised an error or a timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if ((w_err || w_expire) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_hb_wdt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gray_hb_wdt
// Description : Self-checking bench for gray_hb_wdt (table vectors plus
//               hand-written multi-cycle sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_hb_wdt;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] hb;
    logic [3:0] hb4;
    logic       health, seq_err, timeout, cycle_done;
    logic       health4, seq_err4, timeout4, cycle_done4;
`ifdef GRAY_HB_WDT_ERRCNT_EN
    logic [7:0] err_count;
    logic [7:0] err_count4;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] hb;
        logic       h;
        logic       se;
        logic       to;
        logic       cd;
    } vec_t;

    vec_t       tv[$];
    logic [2:0] c_seq [0:6] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

    always #5 clk = ~clk;

    gray_hb_wdt #(.W(3), .TIMEOUT(100), .CNT_W(24), .GOOD_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .hb(hb), .health(health), .seq_err(seq_err),
        .timeout(timeout), .cycle_done(cycle_done)
`ifdef GRAY_HB_WDT_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    gray_hb_wdt #(.W(4), .TIMEOUT(1000), .CNT_W(24), .GOOD_CYCLES(1)) dut4 (
        .clk(clk), .reset(reset), .hb(hb4), .health(health4), .seq_err(seq_err4),
        .timeout(timeout4), .cycle_done(cycle_done4)
`ifdef GRAY_HB_WDT_ERRCNT_EN
        , .err_count(err_count4)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] v);
        hb = v;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic [3:0] v);
        hb4 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [2:0] v, input logic h, input logic se,
                       input logic to, input logic cd);
        vec_t e;
        e.hb = v; e.h = h; e.se = se; e.to = to; e.cd = cd;
        tv.push_back(e);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        hb    = 3'd0;
        hb4   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Two full passes to reach health with GOOD_CYCLES=2
    task automatic two_passes();
        step(3'd0);
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 7; c++) step(c_seq[c]);
            step(3'd0);
        end
    endtask

    function automatic logic [3:0] g4(input int i);
        logic [3:0] v;
        v = 4'(i);
        return v ^ (v >> 1);
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        int n;
        int se_n;

        // ---------------- reset state ----------------
        reset = 1'b1;
        hb    = 3'd0;
        hb4   = 4'd0;
        #12;
        check("rst_health", health, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cycle_done", cycle_done, 0);
        reset_dut();

        // ---------------- table: two passes, codes held 2 cycles, then an error ----------------
        add(3'd0, 0, 0, 0, 0);
        add(3'd0, 0, 0, 0, 0);
        for (int c = 0; c < 7; c++) begin
            add(c_seq[c], 0, 0, 0, 0);
            add(c_seq[c], 0, 0, 0, 0);
        end
        add(3'd0, 0, 0, 0, 1);
        add(3'd0, 0, 0, 0, 0);
        for (int c = 0; c < 7; c++) begin
            add(c_seq[c], 0, 0, 0, 0);
            add(c_seq[c], 0, 0, 0, 0);
        end
        add(3'd0, 1, 0, 0, 1);
        add(3'd0, 1, 0, 0, 0);
        add(3'd1, 1, 0, 0, 0);
        add(3'd2, 0, 1, 0, 0);
        add(3'd2, 0, 0, 0, 0);
        add(3'd0, 0, 0, 0, 0);
        add(3'd1, 0, 0, 0, 0);
        add(3'd3, 0, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].hb);
            check($sformatf("vec%0d_health", i), health, tv[i].h);
            check($sformatf("vec%0d_seq_err", i), seq_err, tv[i].se);
            check($sformatf("vec%0d_timeout", i), timeout, tv[i].to);
            check($sformatf("vec%0d_cycle_done", i), cycle_done, tv[i].cd);
        end

        // ---------------- timeout latency while healthy, hb held at 5 ----------------
        reset_dut();
        two_passes();
        check("a_cd_second", cycle_done, 1);
        check("a_healthy", health, 1);
        k = 0;
        for (int c = 0; c < 6; c++) begin
            step(c_seq[c]);
            k++;
        end
        while (timeout !== 1'b1 && k < 300) begin
            step(3'd5);
            k++;
        end
        check("a_timeout_latency", k, 100);
        check("a_health_after_to", health, 0);
        check("a_no_seq_err", seq_err, 0);
        step(3'd5);
        check("a_timeout_width", timeout, 0);
        n = 0;
        repeat (40) begin
            step(3'd5);
            if (timeout) n++;
        end
        check("a_no_repeat_pulse", n, 0);

        // ---------------- completion on the expiry cycle, then error on expiry ----------------
        step(3'd0);
        for (int c = 0; c < 7; c++) step(c_seq[c]);
        step(3'd0);
        check("b_cd_sync", cycle_done, 1);
        check("b_health_one_pass", health, 0);
        repeat (92) step(3'd0);
        for (int c = 0; c < 7; c++) step(c_seq[c]);
        step(3'd0);
        check("b_done_wins_cd", cycle_done, 1);
        check("b_done_wins_to", timeout, 0);
        check("b_done_wins_health", health, 1);
        n = 0;
        repeat (99) begin
            step(3'd0);
            if (timeout) n++;
        end
        check("b_cnt_cleared", n, 0);
        step(3'd2);
        check("b_both_seq_err", seq_err, 1);
        check("b_both_timeout", timeout, 1);
        check("b_both_health", health, 0);
        step(3'd2);
        check("b_after_seq_err", seq_err, 0);
        check("b_after_timeout", timeout, 0);

        // ---------------- asynchronous reset mid-sequence ----------------
        reset_dut();
        two_passes();
        check("c_healthy", health, 1);
        for (int c = 0; c < 4; c++) step(c_seq[c]);
        check("c_idx_before", dut.r_idx, 4);
        #2;
        reset = 1'b1;
        #1;
        check("c_rst_health", health, 0);
        check("c_rst_cd", cycle_done, 0);
        check("c_rst_se", seq_err, 0);
        check("c_rst_to", timeout, 0);
        check("c_rst_idx", dut.r_idx, 0);
        check("c_rst_cnt", dut.r_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        se_n = 0;
        foreach (c_seq[c]) begin
            if (c >= 4) begin
                step(c_seq[c]);
                n += int'(cycle_done);
                se_n += int'(seq_err);
            end
        end
        step(3'd0);
        n += int'(cycle_done);
        for (int c = 0; c < 3; c++) begin
            step(c_seq[c]);
            n += int'(cycle_done);
            se_n += int'(seq_err);
        end
        check("c_partial_no_cd", n, 0);
        check("c_partial_no_se", se_n, 0);
        check("c_partial_idx", dut.r_idx, 3);

        // ---------------- W=4, GOOD_CYCLES=1 instance ----------------
        reset_dut();
        step4(4'd0);
        for (int i = 1; i < 16; i++) step4(g4(i));
        check("d_health_before_wrap", health4, 0);
        step4(4'd0);
        check("d_wrap_cd", cycle_done4, 1);
        check("d_wrap_health", health4, 1);
        step4(g4(1));
        check("d_adv_ok", seq_err4, 0);
        step4(g4(3));
        check("d_skip_seq_err", seq_err4, 1);
        check("d_skip_health", health4, 0);

`ifdef GRAY_HB_WDT_ERRCNT_EN
        // ---------------- error counter ----------------
        reset_dut();
        repeat (3) begin
            step(3'd0);
            step(3'd2);
        end
        check("e_err_count_3", err_count, 3);
        repeat (297) begin
            step(3'd0);
            step(3'd2);
        end
        check("e_err_count_sat", err_count, 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_hb_wdt.md
GRAY_HB_WDT -- requirements
Module: gray_hb_wdt

Interface
REQ-001 SHALL have parameter W, default 3, giving the heartbeat code width; legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 6100, giving the maximum cycles allowed between completed sequences; legal range 2..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 24, giving the watchdog counter width.
REQ-004 SHALL have parameter GOOD_CYCLES, default 1, giving the consecutive complete sequences required before health asserts; legal range 1..15.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port hb, input, W bits: heartbeat code, synchronous to clk (the caller synchronises it).
REQ-008 SHALL have port health, output, 1 bit: registered; 1 means the monitored unit is healthy.
REQ-009 SHALL have port seq_err, output, 1 bit: registered one-cycle pulse on an illegal code transition.
REQ-010 SHALL have port timeout, output, 1 bit: registered one-cycle pulse on watchdog expiry.
REQ-011 SHALL have port cycle_done, output, 1 bit: registered one-cycle pulse on each completed sequence.

Function
REQ-012 SHALL define the expected code sequence as g(i) = i XOR (i>>1), for i = 0..2^W-1, wrapping from 2^W-1 back to 0.
REQ-013 SHALL implement states IDLE and TRACK, plus an index register idx (W bits) and a good counter gcnt (4 bits).
REQ-014 In IDLE: if hb==0, the block SHALL go to TRACK with idx=0; otherwise it SHALL stay in IDLE with no error.
REQ-015 In TRACK: if hb==g(idx), the block SHALL hold; if hb==g(idx+1 mod 2^W), it SHALL set idx to idx+1 mod 2^W.
REQ-016 In TRACK, any other code SHALL cause: seq_err pulse, state to IDLE, gcnt to 0, health to 0, watchdog counter to 0.
REQ-017 An advance from idx=2^W-1 to idx=0 SHALL cause:
- a cycle_done pulse;
- gcnt to increment, saturating at GOOD_CYCLES;
- the watchdog counter to clear.
REQ-018 health SHALL set to 1 in the cycle after the completion that brings gcnt to GOOD_CYCLES; while gcnt remains saturated it SHALL stay 1.
REQ-019 The watchdog counter SHALL increment every cycle in both states; when it reaches TIMEOUT-1, the block SHALL:
- pulse timeout;
- clear the counter;
- set health=0 and gcnt=0;
- force state to IDLE.
REQ-020 A completion and a timeout in the same cycle SHALL resolve as completion: no timeout pulse, counter cleared.
REQ-021 An error and a timeout in the same cycle SHALL assert both seq_err and timeout; health goes to 0.
REQ-022 All outputs SHALL be registered, with one cycle of latency from the sampling clock edge.
REQ-023 Pulses SHALL never exceed one cycle, even if the triggering condition persists.

Reset
REQ-024 Asserting reset SHALL immediately (asynchronously) force state=IDLE, idx=0, gcnt=0, counter=0, health=0, seq_err=0, timeout=0 and cycle_done=0.
REQ-025 Reset asserted mid-sequence SHALL discard all progress; after release, tracking SHALL restart only from hb==0.

Configuration
REQ-026 With macro GRAY_HB_WDT_ERRCNT_EN defined, the block SHALL add output err_count[7:0]:
- increments on each cycle where seq_err or timeout is generated, by 1 even if both occur;
- saturates at 255;
- cleared only by reset.
REQ-027 Without GRAY_HB_WDT_ERRCNT_EN, the err_count port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
Scenarios use W=3, TIMEOUT=100, GOOD_CYCLES=2 unless stated.
REQ-028 Drive 0,1,3,2,6,7,5,4,0 with each code held for 2 cycles, twice -> two cycle_done pulses; health=0 after the first pass and 1 one cycle after the second return to 0.
REQ-029 When healthy, drive hb 1 then 2 -> one seq_err pulse and health=0 on the next cycle; hb==0 then restarts tracking.
REQ-030 When healthy, hold hb=5 -> timeout pulse 100 cycles after the last cycle_done, then health=0; no repeated pulse while held.
REQ-031 With W=4, TIMEOUT=1000, GOOD_CYCLES=1, drive the 16-code Gray sequence -> health=1 after the first wrap; a skipped code produces seq_err.
REQ-032 Assert reset at idx=4 while healthy -> health, pulses, idx and counter are 0 immediately; after release, a partial sequence produces no cycle_done.
REQ-033 With GRAY_HB_WDT_ERRCNT_EN defined, 3 errors -> err_count=3; forcing 300 errors -> err_count=255.
